// File: rtl/stg4mr_pkg.sv
// stg4mr shared definitions: bus widths, FSM state encodings, wait-counter
// width and the out-of-range address helper used by the responder.
package stg4mr_pkg;

  localparam int SIZE_ADDR = 16;
  localparam int SIZE_DATA = 32;
  localparam int SIZE_MRST = 2;
  localparam int SIZE_WCNT = 4;

  typedef enum logic [SIZE_MRST-1:0] {
    MRST_IDLE = 2'd0,
    MRST_WAIT = 2'd1,
    MRST_RESP = 2'd2
  } mrst_e;

  // True when any address bit above the array index field is set.
  function automatic logic upper_bits_set(input logic [SIZE_ADDR-1:0] addr,
                                          input int depth_log2);
    return (addr >> depth_log2) != '0;
  endfunction

endpackage

// File: rtl/stg4mr_ram.sv
// stg4mr_ram: single-port synchronous word array with write enable and a
// registered read. Read-first on a simultaneous write. Contents are never reset.
module stg4mr_ram
  import stg4mr_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  iw_clk,
  input  logic                  iw_we,
  input  logic [DEPTH_LOG2-1:0] iw_addr,
  input  logic [SIZE_DATA-1:0]  iw_wdata,
  output logic [SIZE_DATA-1:0]  ow_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [SIZE_DATA-1:0] mem [DEPTH];

  // Registered read every cycle; write only when enabled.
  always_ff @(posedge iw_clk) begin
    if (iw_we) begin
      mem[iw_addr] <= iw_wdata;
    end
    ow_rdata <= mem[iw_addr];
  end

endmodule

// File: rtl/stg4mr.sv
// stg4mr: data-memory responder for the stage-4 memory-access interface.
// Selects the ping/pong address, performs a load or store against a local
// array after WAIT_CYCLES wait states and returns data with a one-cycle valid.
// Optional macro STG4MR_RANGE_CHECK_EN: flag addresses with bits set above
// the array index field; such stores are dropped and loads return zero.
module stg4mr
  import stg4mr_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst_n,
  input  logic                 iw_mem_mp,
  input  logic [SIZE_ADDR-1:0] iw_mem_addr0,
  input  logic [SIZE_ADDR-1:0] iw_mem_addr1,
  input  logic                 iw_req,
  input  logic                 iw_we,
  input  logic [SIZE_DATA-1:0] iw_wdata,
  output logic [SIZE_DATA-1:0] ow_rdata,
  output logic                 ow_rvalid,
  output logic                 ow_stall,
  output logic                 ow_err
);

  localparam logic [SIZE_WCNT-1:0] WAIT_INIT = SIZE_WCNT'(WAIT_CYCLES);

  mrst_e                 state_reg, state_next;
  logic [SIZE_WCNT-1:0]  wcnt_reg, wcnt_next;
  logic [DEPTH_LOG2-1:0] cap_idx_reg;
  logic                  cap_we_reg;
  logic                  cap_err_reg;
  logic [SIZE_DATA-1:0]  cap_wdata_reg;

  logic [SIZE_ADDR-1:0]  sel_addr;
  logic [DEPTH_LOG2-1:0] sel_idx;
  logic                  range_hit;
  logic                  accept;
  logic                  in_resp;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;
  logic [SIZE_DATA-1:0]  ram_rdata;

  assign sel_addr = iw_mem_mp ? iw_mem_addr1 : iw_mem_addr0;
  assign sel_idx  = sel_addr[DEPTH_LOG2-1:0];
  assign accept   = iw_req && (state_reg == MRST_IDLE);
  assign in_resp  = (state_reg == MRST_RESP);

`ifdef STG4MR_RANGE_CHECK_EN
  assign range_hit = upper_bits_set(sel_addr, DEPTH_LOG2);
`else
  // Upper address bits wrap away: the array is addressed modulo its depth.
  logic unused_upper;
  assign unused_upper = |sel_addr[SIZE_ADDR-1:DEPTH_LOG2];
  assign range_hit    = 1'b0;
`endif

  // The array is read from the live address while idle so a zero-wait access
  // has its data registered on the accept edge; otherwise the captured index
  // is used, which is also the write address during RESP.
  assign ram_addr = (state_reg == MRST_IDLE) ? sel_idx : cap_idx_reg;
  assign ram_we   = in_resp && cap_we_reg && !cap_err_reg;

  stg4mr_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .iw_clk  (iw_clk),
    .iw_we   (ram_we),
    .iw_addr (ram_addr),
    .iw_wdata(cap_wdata_reg),
    .ow_rdata(ram_rdata)
  );

  // State, wait counter and accepted-request capture.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_reg     <= MRST_IDLE;
      wcnt_reg      <= '0;
      cap_idx_reg   <= '0;
      cap_we_reg    <= 1'b0;
      cap_err_reg   <= 1'b0;
      cap_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      if (accept) begin
        cap_idx_reg   <= sel_idx;
        cap_we_reg    <= iw_we;
        cap_err_reg   <= range_hit;
        cap_wdata_reg <= iw_wdata;
      end
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE, one access at a time.
  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    case (state_reg)
      MRST_IDLE: begin
        if (iw_req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = MRST_RESP;
          end else begin
            state_next = MRST_WAIT;
            wcnt_next  = WAIT_INIT;
          end
        end
      end
      MRST_WAIT: begin
        wcnt_next = wcnt_reg - 1'b1;
        if (wcnt_reg == SIZE_WCNT'(1)) begin
          state_next = MRST_RESP;
        end
      end
      MRST_RESP: state_next = MRST_IDLE;
      default:   state_next = MRST_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    ow_rvalid = in_resp;
    ow_stall  = (state_reg == MRST_WAIT);
    ow_err    = in_resp && cap_err_reg;
    ow_rdata  = '0;
    if (in_resp && !cap_err_reg) begin
      ow_rdata = cap_we_reg ? cap_wdata_reg : ram_rdata;
    end
  end

endmodule
